// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store byte-alignment stage: access sizes, FSM states, base mask.
// Purely declarative; no latency or backpressure of its own.
package lsu_pkg;

  localparam logic [1:0] SZ_B  = 2'b00;
  localparam logic [1:0] SZ_H  = 2'b01;
  localparam logic [1:0] SZ_3B = 2'b10;
  localparam logic [1:0] SZ_W  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    RESP
  } state_e;

  // Low (size+1) bytes set, before any lane shift.
  function automatic logic [31:0] base_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      SZ_B:    m = 32'h0000_00FF;
      SZ_H:    m = 32'h0000_FFFF;
      SZ_3B:   m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_byte_align_if.sv
// Request/response handshake bundle between the execute stage (master) and the LSU (slave).
// Valid/ready on both directions; one access outstanding at a time.
interface lsu_byte_align_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane shifter: extracts/extends load data and merges store data into the old word.
// Zero latency; no handshake.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] old,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] wr_data
);

  logic [4:0]  sh;
  logic [31:0] m;
  logic [31:0] lm;
  logic [31:0] raw;
  logic        sbit;

  always_comb begin
    sh   = {off, 3'b000};
    m    = base_mask(size);
    // Bytes pushed past lane 3 fall off the top of the 32-bit lane mask.
    lm   = m << sh;
    raw  = (old >> sh) & m;
    sbit = raw[{size, 3'b111}];
    ld_data = raw;
    if (sgn && (size != SZ_W) && sbit) begin
      ld_data = raw | ~m;
    end
    wr_data = (old & ~lm) | ((wdata << sh) & lm);
  end

endmodule

// File: rtl/lsu_byte_align.sv
// Sub-word load/store stage over a word-only memory (RMW for partial stores); load 3, store 2/4 cycles.
// One access in flight, RESP held until resp_ready; LSU_MISALIGN_TRAP_EN turns lane crossing into an error.
module lsu_byte_align
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_byte_align_if.slave   bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              sgn_q;
  logic              err_q;
  logic [31:0]       wdata_q;
  logic [31:0]       old_q;
  logic [31:0]       ld_data;
  logic [31:0]       wr_data;
  logic              accept;
  logic              trap;
  logic              full_st;

  assign accept  = bus.req_valid && bus.req_ready;
  assign full_st = (bus.req_size == SZ_W) && (bus.req_addr[1:0] == 2'b00);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ({1'b0, bus.req_addr[1:0]} + {1'b0, bus.req_size}) > 3'd3;
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (trap)                     state_nxt = RESP;
          else if (bus.req_we && full_st) state_nxt = WR;
          else                          state_nxt = RD;
        end
      end
      RD: begin
        mem_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: state_nxt = we_q ? WR : RESP;
      WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= SZ_B;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      old_q   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        size_q  <= bus.req_size;
        we_q    <= bus.req_we;
        sgn_q   <= bus.req_signed;
        err_q   <= trap;
        wdata_q <= bus.req_wdata;
        // Zero old word so a full-word store merges to exactly wdata without a read.
        old_q   <= '0;
      end
      if (state == WAIT) old_q <= mem_rdata;
    end
  end

  lsu_lane_align u_lane (
    .off     (addr_q[1:0]),
    .size    (size_q),
    .sgn     (sgn_q),
    .old     (old_q),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .wr_data (wr_data)
  );

  assign mem_addr       = addr_q[ADDR_W-1:2];
  assign mem_wdata      = (state == WR) ? wr_data : 32'h0;
  assign bus.resp_rdata = ((state == RESP) && !we_q && !err_q) ? ld_data : 32'h0;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu_byte_align.sv
// Bench for lsu_byte_align: directed cases plus random traffic against a byte-level reference model.
// Works with or without LSU_MISALIGN_TRAP_EN.
module tb_lsu_byte_align;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_byte_align_if #(.ADDR_W(32)) ifc();

  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_byte_align #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] tb_mem   [16];
  logic [31:0] init_mem [16];
  logic [31:0] ref_mem  [16];
  logic        preload = 1'b0;
  int n_chk = 0;
  int n_err = 0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= init_mem[i];
    end else if (mem_en) begin
      if (mem_we) tb_mem[int'(mem_addr) & 15] <= mem_wdata;
      else        mem_rdata <= tb_mem[int'(mem_addr) & 15];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-by-byte reference: pick bytes off..off+size that still lie inside the word.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int sz, input logic sg);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i <= sz; i++)
      if (off + i < 4) r[8*i +: 8] = w[8*(off+i) +: 8];
    if (sg && sz != 3 && r[8*sz+7])
      for (int i = sz + 1; i < 4; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input int off, input int sz, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    for (int i = 0; i <= sz; i++)
      if (off + i < 4) r[8*(off+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic do_op(input logic we, input logic [1:0] sz, input logic sg, input logic [5:0] a,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd_o, output logic err_o);
    int w, off, isz, lat, nrd, nwr, wcyc, rcyc, tmo, exp_lat;
    logic trap, full;
    logic [31:0] exp_rd, exp_wd, wdat;
    w    = int'(a[5:2]);
    off  = int'(a[1:0]);
    isz  = int'(sz);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (off + isz) > 3;
`else
    trap = 1'b0;
`endif
    full   = we && isz == 3 && off == 0;
    exp_rd = (!we && !trap) ? ref_load(ref_mem[w], off, isz, sg) : 32'h0;
    exp_wd = ref_store(ref_mem[w], off, isz, wd);
    if (trap)      exp_lat = 1;
    else if (!we)  exp_lat = 3;
    else if (full) exp_lat = 2;
    else           exp_lat = 4;
    if (we && !trap) ref_mem[w] = exp_wd;

    @(negedge clk);
    ifc.req_valid  = 1'b1;
    ifc.req_we     = we;
    ifc.req_size   = sz;
    ifc.req_signed = sg;
    ifc.req_addr   = {26'h0, a};
    ifc.req_wdata  = wd;
    tmo = 0;
    while (!ifc.req_ready && tmo < 10) begin
      @(negedge clk);
      tmo++;
    end
    chk("accept", 32'(ifc.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ifc.req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; wcyc = 0; rcyc = 0; wdat = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_en && !mem_we) begin nrd++; rcyc = k; end
      if (mem_en && mem_we)  begin nwr++; wcyc = k; wdat = mem_wdata; end
      if (ifc.resp_valid) begin lat = k; break; end
    end
    chk("lat",   32'(lat), 32'(exp_lat));
    chk("rdata", ifc.resp_rdata, exp_rd);
    chk("err",   32'(ifc.resp_err), 32'(trap));
    chk("nrd",   32'(nrd), 32'(!trap && !full));
    chk("nwr",   32'(nwr), 32'(we && !trap));
    if (we && !trap) begin
      chk("wdat", wdat, exp_wd);
      chk("wcyc", 32'(wcyc), 32'(exp_lat - 1));
    end
    if (!trap && !full) chk("rcyc", 32'(rcyc), 32'd1);
    rd_o  = ifc.resp_rdata;
    err_o = ifc.resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_v",  32'(ifc.resp_valid), 32'd1);
      chk("hold_d",  ifc.resp_rdata, exp_rd);
      chk("hold_rr", 32'(ifc.req_ready), 32'd0);
    end
    ifc.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.resp_ready = 1'b0;
    chk("idle_rr", 32'(ifc.req_ready), 32'd1);
    chk("idle_v",  32'(ifc.resp_valid), 32'd0);
    chk("mem",     tb_mem[w], ref_mem[w]);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          nwr;
    ifc.req_valid  = 1'b0;
    ifc.req_we     = 1'b0;
    ifc.req_size   = 2'b00;
    ifc.req_signed = 1'b0;
    ifc.req_addr   = 32'h0;
    ifc.req_wdata  = 32'h0;
    ifc.resp_ready = 1'b0;
    for (int i = 0; i < 16; i++) init_mem[i] = $urandom;
    init_mem[4] = 32'h8899AABB;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_mem[i];

    preload = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    preload = 1'b0;
    @(negedge clk);
    chk("rst_rv",  32'(ifc.resp_valid), 32'd0);
    chk("rst_rd",  ifc.resp_rdata, 32'h0);
    chk("rst_err", 32'(ifc.resp_err), 32'd0);
    chk("rst_en",  32'(mem_en), 32'd0);
    chk("rst_we",  32'(mem_we), 32'd0);
    chk("rst_wd",  mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_rr", 32'(ifc.req_ready), 32'd1);

    do_op(1'b0, 2'b00, 1'b1, 6'h13, 32'h0, 0, rd, er);
    chk("t_lb13", rd, 32'hFFFFFF88);
    chk("t_lb13_err", 32'(er), 32'd0);
    do_op(1'b0, 2'b01, 1'b0, 6'h12, 32'h0, 0, rd, er);
    chk("t_lhu12", rd, 32'h00008899);
    do_op(1'b0, 2'b01, 1'b1, 6'h10, 32'h0, 0, rd, er);
    chk("t_lh10", rd, 32'hFFFFAABB);
    do_op(1'b0, 2'b01, 1'b0, 6'h13, 32'h0, 0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("t_lh13_err", 32'(er), 32'd1);
    chk("t_lh13_rd", rd, 32'h0);
`else
    chk("t_lh13_rd", rd, 32'h00000088);
`endif
    do_op(1'b1, 2'b00, 1'b0, 6'h11, 32'h000000CC, 0, rd, er);
    chk("t_sb11_mem", tb_mem[4], 32'h8899CCBB);
    do_op(1'b1, 2'b11, 1'b0, 6'h10, 32'h12345678, 0, rd, er);
    chk("t_sw10_mem", tb_mem[4], 32'h12345678);
    chk("t_sw10_rd", rd, 32'h0);
    do_op(1'b0, 2'b11, 1'b0, 6'h10, 32'h0, 3, rd, er);
    chk("t_bp_rd", rd, 32'h12345678);

    // Reset while a partial store sits in WAIT: the write must never happen.
    @(negedge clk);
    ifc.req_valid  = 1'b1;
    ifc.req_we     = 1'b1;
    ifc.req_size   = 2'b00;
    ifc.req_signed = 1'b0;
    ifc.req_addr   = 32'h15;
    ifc.req_wdata  = 32'h000000A5;
    @(posedge clk);
    @(negedge clk);
    ifc.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nwr = 0;
    for (int k = 0; k < 7; k++) begin
      if (mem_en && mem_we) nwr++;
      @(negedge clk);
    end
    chk("mid_rst_nwr", 32'(nwr), 32'd0);
    chk("mid_rst_mem", tb_mem[5], ref_mem[5]);
    chk("mid_rst_rr",  32'(ifc.req_ready), 32'd1);
    chk("mid_rst_rv",  32'(ifc.resp_valid), 32'd0);

    for (int n = 0; n < 200; n++) begin
      do_op(1'($urandom), 2'($urandom), 1'($urandom), 6'($urandom_range(0, 63)),
            $urandom, int'($urandom_range(0, 2)), rd, er);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
